// File: rtl/AHB_package.sv
// rtl/AHB_package.sv - shared AHB-Lite transfer type and size encodings
package AHB_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

endpackage

// File: rtl/ahb_sram_lane_wr.sv
// rtl/ahb_sram_lane_wr.sv - little-endian byte enables and lane-masked write data
module ahb_sram_lane_wr
  import AHB_package::*;
(
  input  hsize_e      size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o = 4'b0000;
    case (size_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be_o = 4'b1111;
      default:    be_o = 4'b0000;
    endcase
  end

  // Write data already sits on its AHB byte lane; unused lanes are zeroed.
  always_comb begin
    wdata_o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      wdata_o[8*i +: 8] = be_o[i] ? wdata_i[8*i +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/ahb_slave_sram.sv
// rtl/ahb_slave_sram.sv - AHB-Lite SRAM slave with programmable wait states and ERROR responses
module ahb_slave_sram
  import AHB_package::*;
#(
  parameter int MEM_BYTES   = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              dp_valid_q, dp_write_q;
  logic [IDX_W+1:0]  dp_addr_q;
  hsize_e            dp_size_q;
  logic [31:0]       mem [WORDS];

  logic              accept, legal, wr_en;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;

  always_comb begin
    accept = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    legal  = (haddr < ADDR_W'(MEM_BYTES)) && (hsize <= 3'd2)
          && !(hsize == HSIZE_HALF && haddr[0])
          && !(hsize == HSIZE_WORD && haddr[1:0] != 2'b00);
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: begin
        hresp   = (state_q == S_ERR2);
        state_d = S_IDLE;
        if (accept) begin
          if (!legal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 3'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address phase is only taken when the bus is ready; errored captures leave no data phase.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= HSIZE_BYTE;
    end else if (hready) begin
      dp_valid_q <= accept && legal;
      dp_write_q <= hwrite;
      dp_addr_q  <= haddr[IDX_W+1:0];
      dp_size_q  <= hsize_e'(hsize);
    end
  end

  ahb_sram_lane_wr u_lane_wr (
    .size_i    (dp_size_q),
    .addr_lo_i (dp_addr_q[1:0]),
    .wdata_i   (hwdata),
    .be_o      (be),
    .wdata_o   (wdata_lane)
  );

  assign wr_en = hreset_n && dp_valid_q && dp_write_q && hreadyout;

  always_ff @(posedge hclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[dp_addr_q[IDX_W+1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign hrdata = (dp_valid_q && !dp_write_q) ? mem[dp_addr_q[IDX_W+1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// tb/tb_ahb_slave_sram.sv - directed bench for ahb_slave_sram at zero and three wait states
module tb_ahb_slave_sram;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        use3;

  logic        ro0, rs0, ro3, rs3;
  logic [31:0] rd0, rd3;
  logic        hsel0, hsel3, hready, hresp_m;
  logic [31:0] hrdata_m;

  int total = 0;
  int bad   = 0;

  assign hsel0    = hsel & ~use3;
  assign hsel3    = hsel & use3;
  assign hready   = use3 ? ro3 : ro0;
  assign hresp_m  = use3 ? rs3 : rs0;
  assign hrdata_m = use3 ? rd3 : rd0;

  always #5 hclk = ~hclk;

  ahb_slave_sram #(.MEM_BYTES(1024), .ADDR_W(32), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
  );

  ahb_slave_sram #(.MEM_BYTES(1024), .ADDR_W(32), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro3), .hresp(rs3), .hrdata(rd3)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [1:0] tr);
    hsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = tr;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'd0;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic r_first, output logic r_last);
    addr_ph(wr, a, sz, 2'd2);
    tick();
    idle_bus();
    hwdata  = wd;
    r_first = hresp_m;
    waits   = 0;
    while (hready !== 1'b1 && waits < 20) begin
      tick();
      waits++;
    end
    rd     = hrdata_m;
    r_last = hresp_m;
    tick();
  endtask

  logic [31:0] rd;
  logic        rf, rl;
  int          w, n;

  initial begin
    use3 = 1'b0; hreset_n = 1'b0; hwdata = 32'h0; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd2;
    idle_bus();
    tick(); tick();
    chk("rst_hreadyout", 32'(ro0), 32'd1);
    chk("rst_hresp", 32'(rs0), 32'd0);
    chk("rst_hrdata", rd0, 32'h0);
    chk("rst_hreadyout_ws3", 32'(ro3), 32'd1);
    hreset_n = 1'b1;
    tick();

    // Pipelined write then read of 0x10 with no wait states
    addr_ph(1'b1, 32'h10, 3'd2, 2'd2);
    tick();
    hwdata = 32'hDEADBEEF;
    addr_ph(1'b0, 32'h10, 3'd2, 2'd2);
    chk("wr_dp_ready", 32'(hready), 32'd1);
    tick();
    idle_bus();
    chk("rd_dp_ready", 32'(hready), 32'd1);
    chk("rd_dp_resp", 32'(hresp_m), 32'd0);
    chk("rd_dp_data", hrdata_m, 32'hDEADBEEF);
    tick();
    chk("idle_hrdata", hrdata_m, 32'h0);

    // Byte and half-word lane writes; data replicated across lanes
    xfer(1'b1, 32'h10, 3'd2, 32'h11223344, rd, w, rf, rl);
    chk("word_wr_waits", 32'(w), 32'd0);
    xfer(1'b1, 32'h13, 3'd0, 32'hAAAAAAAA, rd, w, rf, rl);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, w, rf, rl);
    chk("byte_rd", rd, 32'hAA223344);
    xfer(1'b1, 32'h12, 3'd1, 32'h55665566, rd, w, rf, rl);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, w, rf, rl);
    chk("half_rd", rd, 32'h55663344);
    chk("half_rd_resp", 32'(rl), 32'd0);

    // ERROR responses
    xfer(1'b1, 32'h0, 3'd2, 32'h0BADF00D, rd, w, rf, rl);
    xfer(1'b0, 32'h400, 3'd2, 32'h0, rd, w, rf, rl);
    chk("oob_err1_resp", 32'(rf), 32'd1);
    chk("oob_wait", 32'(w), 32'd1);
    chk("oob_err2_resp", 32'(rl), 32'd1);
    xfer(1'b1, 32'h2, 3'd2, 32'hFFFFFFFF, rd, w, rf, rl);
    chk("misal_err1_resp", 32'(rf), 32'd1);
    chk("misal_wait", 32'(w), 32'd1);
    chk("misal_err2_resp", 32'(rl), 32'd1);
    xfer(1'b1, 32'h4, 3'd3, 32'hFFFFFFFF, rd, w, rf, rl);
    chk("badsize_wait", 32'(w), 32'd1);
    xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, w, rf, rl);
    chk("after_err_data", rd, 32'h0BADF00D);
    chk("after_err_resp", 32'(rl), 32'd0);
    chk("after_err_waits", 32'(w), 32'd0);
    xfer(1'b0, 32'h4, 3'd2, 32'h0, rd, w, rf, rl);
    chk("badsize_no_write", 32'(rd === 32'hFFFFFFFF), 32'd0);

    // Incrementing burst at 0x20 with one BUSY
    addr_ph(1'b1, 32'h20, 3'd2, 2'd2);
    tick();
    hwdata = 32'hA0A0A0A0;
    addr_ph(1'b1, 32'h24, 3'd2, 2'd3);
    tick();
    hwdata = 32'hA1A1A1A1;
    addr_ph(1'b1, 32'h28, 3'd2, 2'd1);
    tick();
    chk("busy_ready", 32'(hready), 32'd1);
    chk("busy_resp", 32'(hresp_m), 32'd0);
    addr_ph(1'b1, 32'h28, 3'd2, 2'd3);
    tick();
    hwdata = 32'hA2A2A2A2;
    addr_ph(1'b1, 32'h2C, 3'd2, 2'd3);
    tick();
    hwdata = 32'hA3A3A3A3;
    idle_bus();
    tick();
    xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, w, rf, rl);
    chk("burst0", rd, 32'hA0A0A0A0);
    xfer(1'b0, 32'h24, 3'd2, 32'h0, rd, w, rf, rl);
    chk("burst1", rd, 32'hA1A1A1A1);
    xfer(1'b0, 32'h28, 3'd2, 32'h0, rd, w, rf, rl);
    chk("burst2", rd, 32'hA2A2A2A2);
    xfer(1'b0, 32'h2C, 3'd2, 32'h0, rd, w, rf, rl);
    chk("burst3", rd, 32'hA3A3A3A3);

    // Three wait states
    use3 = 1'b1;
    tick();
    xfer(1'b1, 32'h30, 3'd2, 32'h01020304, rd, w, rf, rl);
    chk("ws3_wr_waits", 32'(w), 32'd3);
    chk("ws3_wr_resp", 32'(rl), 32'd0);

    addr_ph(1'b1, 32'h40, 3'd2, 2'd2);
    tick();
    hwdata = 32'h12345678;
    addr_ph(1'b0, 32'h40, 3'd2, 2'd2);
    n = 0;
    while (hready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("ws3_pipe_wr_low", 32'(n), 32'd3);
    tick();
    idle_bus();
    n = 0;
    while (hready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("ws3_pipe_rd_low", 32'(n), 32'd3);
    chk("ws3_pipe_rd_data", hrdata_m, 32'h12345678);
    tick();

    // Reset during the WAIT of a write to 0x30
    addr_ph(1'b1, 32'h30, 3'd2, 2'd2);
    tick();
    idle_bus();
    hwdata = 32'hCAFEF00D;
    chk("ws3_in_wait", 32'(ro3), 32'd0);
    tick();
    hreset_n = 1'b0;
    tick();
    chk("midrst_hreadyout", 32'(ro3), 32'd1);
    chk("midrst_hresp", 32'(rs3), 32'd0);
    chk("midrst_hrdata", rd3, 32'h0);
    hreset_n = 1'b1;
    tick();
    xfer(1'b0, 32'h30, 3'd2, 32'h0, rd, w, rf, rl);
    chk("midrst_old_data", rd, 32'h01020304);
    chk("midrst_rd_waits", 32'(w), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
